// File: rtl/regfile_wr_sched_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_wr_sched_if : writeback request bus + register-file write port | rev 1.0
// -----------------------------------------------------------------------------
interface regfile_wr_sched_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_en;
  logic [ADDR_W-1:0]         result_addr;
  logic [DATA_W-1:0]         din;
  logic                      init_done;
  logic                      busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, result_addr, din, init_done, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, result_addr, din, init_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_wr_sched : round-robin register-file write-port scheduler      | rev 1.0
// Optional post-reset zero sweep of registers 1..2**ADDR_W-1: REGFILE_INIT_EN
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_REQ = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  regfile_wr_sched_if.slave bus
);

  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [PTR_W-1:0]  next_ptr;
  logic              arb_active;

`ifdef REGFILE_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  assign arb_active    = (state == ST_ARB);
  assign bus.init_done = (state == ST_ARB);
`else
  assign arb_active    = 1'b1;
  assign bus.init_done = 1'b1;
`endif

  // Two passes give the first valid at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (i >= int'(rr_ptr))) begin
        found    = 1'b1;
        win      = PTR_W'(i);
        win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (i < int'(rr_ptr))) begin
        found    = 1'b1;
        win      = PTR_W'(i);
        win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (win == LAST_REQ) ? '0 : win + 1'b1;

  // Reset gates ready so no grant is ever visible while reset is held.
  assign bus.req_ready = (found && arb_active && rst) ? (NUM_REQ'(1) << win) : '0;
  assign bus.busy      = bus.wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wr_en       <= 1'b0;
      bus.result_addr <= '0;
      bus.din         <= '0;
      rr_ptr          <= '0;
`ifdef REGFILE_INIT_EN
      state           <= ST_INIT;
      cnt             <= ADDR_W'(1);
`endif
    end else begin
`ifdef REGFILE_INIT_EN
      case (state)
        ST_INIT: begin
          bus.wr_en       <= 1'b1;
          bus.result_addr <= cnt;
          bus.din         <= '0;
          if (cnt == '1) begin
            state <= ST_ARB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          bus.wr_en <= found && (win_addr != '0);
          if (found) begin
            bus.result_addr <= win_addr;
            bus.din         <= win_data;
            rr_ptr          <= next_ptr;
          end
        end
      endcase
`else
      // Address-0 transfers are accepted and loaded, but never enabled.
      bus.wr_en <= found && (win_addr != '0);
      if (found) begin
        bus.result_addr <= win_addr;
        bus.din         <= win_data;
        rr_ptr          <= next_ptr;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_sched.sv
`default_nettype none
// tb_regfile_wr_sched : directed vector table, reset corner cases and a
// randomized run against a queue-style round-robin reference model.
module tb_regfile_wr_sched;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 3;
  localparam int NREG = 32;
`ifdef REGFILE_INIT_EN
  localparam logic [DW-1:0] PRELOAD = 32'hA5A5_A5A5;
`else
  localparam logic [DW-1:0] PRELOAD = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_sched_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REQ(N)) bus ();

  regfile_wr_sched #(.DATA_W(DW), .ADDR_W(AW), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file fed by the scheduler's write port.
  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] rf_written = '0;
  always @(posedge clk) begin
    if (bus.wr_en) begin
      rf[bus.result_addr]         <= bus.din;
      rf_written[bus.result_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] rf_read(input int a);
    if (a == 0) return '0;
    return rf_written[a] ? rf[a] : PRELOAD;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            wr;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
  } vec_t;

  vec_t          tbl [12];
  logic [DW-1:0] exp_rf [NREG];

  // Reference model state
  bit            pend  [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] pdata [N];
  int            mrr;
  int            w;
  int            idx;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  logic [N-1:0]  er;
  logic          ewr;
  logic [DW-1:0] saved;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        valid   addr {a2,a1,a0}        data {d2,d1,d0}                                 ready   wr    waddr  wdata
    tbl[0]  = '{3'b111, {5'd3, 5'd2, 5'd1},  {32'h33, 32'h22, 32'h11},                       3'b001, 1'b1, 5'd1,  32'h11};
    tbl[1]  = '{3'b110, {5'd3, 5'd2, 5'd1},  {32'h33, 32'h22, 32'h11},                       3'b010, 1'b1, 5'd2,  32'h22};
    tbl[2]  = '{3'b100, {5'd3, 5'd2, 5'd1},  {32'h33, 32'h22, 32'h11},                       3'b100, 1'b1, 5'd3,  32'h33};
    tbl[3]  = '{3'b010, {5'd0, 5'd7, 5'd0},  {32'h0, 32'hDEAD_BEEF, 32'h0},                  3'b010, 1'b1, 5'd7,  32'hDEAD_BEEF};
    tbl[4]  = '{3'b111, {5'd3, 5'd2, 5'd1},  {32'h66, 32'h55, 32'h44},                       3'b100, 1'b1, 5'd3,  32'h66};
    tbl[5]  = '{3'b011, {5'd3, 5'd2, 5'd1},  {32'h66, 32'h55, 32'h44},                       3'b001, 1'b1, 5'd1,  32'h44};
    tbl[6]  = '{3'b010, {5'd3, 5'd2, 5'd1},  {32'h66, 32'h55, 32'h44},                       3'b010, 1'b1, 5'd2,  32'h55};
    tbl[7]  = '{3'b001, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h1234_5678},                  3'b001, 1'b0, 5'd0,  32'h1234_5678};
    tbl[8]  = '{3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},                          3'b000, 1'b0, 5'd0,  32'h1234_5678};
    tbl[9]  = '{3'b001, {5'd0, 5'd0, 5'd5},  {32'h0, 32'h0, 32'hA0A0_A0A0},                  3'b001, 1'b1, 5'd5,  32'hA0A0_A0A0};
    tbl[10] = '{3'b010, {5'd0, 5'd5, 5'd0},  {32'h0, 32'hB0B0_B0B0, 32'h0},                  3'b010, 1'b1, 5'd5,  32'hB0B0_B0B0};
    tbl[11] = '{3'b101, {5'd10, 5'd0, 5'd9}, {32'hD0D0_D0D0, 32'h0, 32'hC0C0_C0C0},          3'b100, 1'b1, 5'd10, 32'hD0D0_D0D0};

    for (int a = 0; a < NREG; a++) exp_rf[a] = (a == 0) ? '0 : PRELOAD;

    // Reset state, with requests pending to show ready is held low.
    rst           = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = '0;
    step();
    step();
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_result_addr", bus.result_addr, '0);
    check("rst_din", bus.din, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_req_ready", bus.req_ready, '0);
`ifdef REGFILE_INIT_EN
    check("rst_init_done", bus.init_done, 1'b0);
`else
    check("rst_init_done", bus.init_done, 1'b1);
`endif
    bus.req_valid = '0;
    #3 rst = 1'b1;

`ifdef REGFILE_INIT_EN
    for (int c = 1; c < NREG; c++) begin
      step();
      check($sformatf("sweep_wr_en[%0d]", c), bus.wr_en, 1'b1);
      check($sformatf("sweep_addr[%0d]", c), bus.result_addr, c);
      check($sformatf("sweep_din[%0d]", c), bus.din, '0);
      check($sformatf("sweep_init_done[%0d]", c), bus.init_done, (c == NREG - 1));
      exp_rf[c] = '0;
    end
`else
    step();
`endif

    // Directed vector table: arbitration order, zero suppression, idle hold.
    for (int r = 0; r < 12; r++) begin
      bus.req_valid = tbl[r].valid;
      bus.req_addr  = tbl[r].addr;
      bus.req_data  = tbl[r].data;
      #3;
      check($sformatf("tbl_ready[%0d]", r), bus.req_ready, tbl[r].ready);
      step();
      check($sformatf("tbl_wr_en[%0d]", r), bus.wr_en, tbl[r].wr);
      check($sformatf("tbl_busy[%0d]", r), bus.busy, tbl[r].wr);
      check($sformatf("tbl_addr[%0d]", r), bus.result_addr, tbl[r].waddr);
      check($sformatf("tbl_din[%0d]", r), bus.din, tbl[r].wdata);
      if (tbl[r].wr) exp_rf[tbl[r].waddr] = tbl[r].wdata;
    end
    bus.req_valid = '0;
    step();
    check("idle_wr_en", bus.wr_en, 1'b0);
    check("reg7", rf_read(7), 32'hDEAD_BEEF);
    check("reg5_last_grant", rf_read(5), 32'hB0B0_B0B0);
    check("reg0_never_written", rf_written[0], 1'b0);
`ifdef REGFILE_INIT_EN
    check("reg31_swept", rf_read(31), '0);
`endif

    // Randomized run against the reference model.
    mrr       = 0;
    last_addr = 5'd10;
    last_din  = 32'hD0D0_D0D0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom_range(NREG - 1, 0));
          pdata[i] = $urandom;
        end
        bus.req_valid[i]           = pend[i];
        bus.req_addr[i*AW +: AW]   = paddr[i];
        bus.req_data[i*DW +: DW]   = pdata[i];
      end
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mrr + k) % N;
        if (w < 0 && pend[idx]) w = idx;
      end
      er  = '0;
      ewr = 1'b0;
      if (w >= 0) begin
        er[w]     = 1'b1;
        ewr       = (paddr[w] != '0);
        last_addr = paddr[w];
        last_din  = pdata[w];
      end
      #3;
      check("rnd_ready", bus.req_ready, er);
      step();
      check("rnd_wr_en", bus.wr_en, ewr);
      check("rnd_addr", bus.result_addr, last_addr);
      check("rnd_din", bus.din, last_din);
      if (w >= 0) begin
        if (ewr) exp_rf[paddr[w]] = pdata[w];
        pend[w] = 1'b0;
        mrr     = (w + 1) % N;
      end
    end
    bus.req_valid = '0;
    step();
    for (int a = 1; a < NREG; a++) check($sformatf("rf_final[%0d]", a), rf_read(a), exp_rf[a]);
    check("rf_final_reg0_untouched", rf_written[0], 1'b0);

    // Reset right after an acceptance: the pending write must be dropped.
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd4};
    bus.req_data  = {32'h0, 32'h0, 32'h7777_7777};
    step();
    check("pre_reset_wr_en", bus.wr_en, 1'b1);
    saved = rf_read(4);
    rst   = 1'b0;
    #1;
    check("async_rst_wr_en", bus.wr_en, 1'b0);
    check("async_rst_addr", bus.result_addr, '0);
    check("async_rst_din", bus.din, '0);
    check("async_rst_ready", bus.req_ready, '0);
    bus.req_valid = '0;
    step();
    step();
    check("lost_write_reg4", rf_read(4), saved);

`ifdef REGFILE_INIT_EN
    #3 rst = 1'b1;
    for (int c = 1; c < 10; c++) begin
      step();
      check($sformatf("pre_abort_addr[%0d]", c), bus.result_addr, c);
    end
    rst = 1'b0;
    #1;
    check("mid_init_rst_wr_en", bus.wr_en, 1'b0);
    check("mid_init_rst_init_done", bus.init_done, 1'b0);
    #3 rst = 1'b1;
    for (int c = 1; c < NREG; c++) begin
      step();
      check($sformatf("resweep_wr_en[%0d]", c), bus.wr_en, 1'b1);
      check($sformatf("resweep_addr[%0d]", c), bus.result_addr, c);
      check($sformatf("resweep_init_done[%0d]", c), bus.init_done, (c == NREG - 1));
    end
    step();
    check("after_resweep_wr_en", bus.wr_en, 1'b0);
    check("after_resweep_init_done", bus.init_done, 1'b1);
`else
    bus.req_valid = 3'b100;
    bus.req_addr  = {5'd31, 5'd0, 5'd0};
    bus.req_data  = {32'd5, 32'h0, 32'h0};
    #1;
    check("in_rst_ready", bus.req_ready, '0);
    rst = 1'b1;
    #1;
    check("first_cycle_init_done", bus.init_done, 1'b1);
    check("first_cycle_ready", bus.req_ready, 3'b100);
    step();
    bus.req_valid = '0;
    check("first_write_wr_en", bus.wr_en, 1'b1);
    check("first_write_addr", bus.result_addr, 5'd31);
    check("first_write_din", bus.din, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
